// File: rtl/seqchk_pkg.sv
// Shared types, defaults and helpers for the seqchk_multi implication checker.
// Optional assertions are compiled in with SEQCHK_SVA_EN.
package seqchk_pkg;

   localparam int unsigned DEF_N_CH    = 2;
   localparam int unsigned DEF_ANT_LEN = 3;
   localparam int unsigned DEF_MIN_DLY = 1;
   localparam int unsigned DEF_MAX_DLY = 4;
   localparam int unsigned DEF_N_SLOT  = 4;
   localparam int unsigned DEF_CNT_W   = 8;

   localparam int unsigned AGE_W = $clog2(DEF_MAX_DLY + 1);

   typedef struct packed {
      logic             valid;
      logic [AGE_W-1:0] age;
   } slot_t;

   // Add b to a, clamping at 2^w-1 (w < 64).
   function automatic longint unsigned sat_add(input longint unsigned a,
                                               input longint unsigned b,
                                               input int unsigned     w);
      longint unsigned lim;
      longint unsigned sum;
      lim = (64'd1 << w) - 64'd1;
      sum = a + b;
      return (sum > lim) ? lim : sum;
   endfunction

endpackage

// File: rtl/seqchk_chan.sv
// One checker channel: antecedent progress chain, pending-attempt slots, counters, overflow.
// With SEQCHK_SVA_EN defined, a reference assertion and cross-checks are added.
module seqchk_chan
   import seqchk_pkg::*;
#(
   parameter int unsigned ANT_LEN = DEF_ANT_LEN,
   parameter int unsigned MIN_DLY = DEF_MIN_DLY,
   parameter int unsigned MAX_DLY = DEF_MAX_DLY,
   parameter int unsigned N_SLOT  = DEF_N_SLOT,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic [ANT_LEN-1:0] ant_i,
   input  logic               trig_i,
   input  logic               resp_i,
   output logic               pass_o,
   output logic               fail_o,
   output logic [CNT_W-1:0]   pass_cnt_o,
   output logic [CNT_W-1:0]   fail_cnt_o,
   output logic               ovf_o,
   output logic               busy_o
);

   localparam logic [AGE_W-1:0] MIN_A = AGE_W'(MIN_DLY);
   localparam logic [AGE_W-1:0] MAX_A = AGE_W'(MAX_DLY);

   if (MAX_DLY >= (1 << AGE_W)) begin : g_age_chk
      $error("MAX_DLY does not fit the slot age field");
   end

   logic match;

   if (ANT_LEN == 1) begin : g_single
      assign match = en_i & ant_i[0];
   end else begin : g_chain
      logic [ANT_LEN-2:0] prog_q, prog_d;

      always_comb begin
         prog_d = '0;
         if (en_i) begin
            prog_d[0] = ant_i[0];
            for (int k = 1; k < ANT_LEN - 1; k++) prog_d[k] = prog_q[k-1] & ant_i[k];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) prog_q <= '0;
         else        prog_q <= prog_d;
      end

      assign match = en_i & prog_q[ANT_LEN-2] & ant_i[ANT_LEN-1];
   end

   slot_t [N_SLOT-1:0] slot_q, slot_d;
   logic               pass_q, pass_d, fail_q, fail_d, ovf_q, ovf_d;
   logic [CNT_W-1:0]   pcnt_q, pcnt_d, fcnt_q, fcnt_d;
   int unsigned        n_pass, n_fail;
   logic               found;

   always_comb begin
      slot_d = slot_q;
      ovf_d  = ovf_q;
      n_pass = 0;
      n_fail = 0;
      found  = 1'b0;
      // The register holds the age the slot will have in the cycle it is visible.
      for (int s = 0; s < N_SLOT; s++) begin
         if (slot_q[s].valid) begin
            if (resp_i && (slot_q[s].age >= MIN_A)) begin
               slot_d[s] = '0;
               n_pass    = n_pass + 1;
            end else if (slot_q[s].age == MAX_A) begin
               slot_d[s] = '0;
               n_fail    = n_fail + 1;
            end else begin
               slot_d[s].age = slot_q[s].age + 1'b1;
            end
         end
      end
      if (match) begin
         if (!trig_i) begin
            n_fail = n_fail + 1;
         end else begin
            // Only slots free at the start of the cycle are candidates.
            for (int s = 0; s < N_SLOT; s++) begin
               if (!slot_q[s].valid && !found) begin
                  slot_d[s].valid = 1'b1;
                  slot_d[s].age   = AGE_W'(1);
                  found           = 1'b1;
               end
            end
            if (!found) ovf_d = 1'b1;
         end
      end
      pass_d = (n_pass != 0);
      fail_d = (n_fail != 0);
      pcnt_d = CNT_W'(sat_add(64'(pcnt_q), 64'(n_pass), CNT_W));
      fcnt_d = CNT_W'(sat_add(64'(fcnt_q), 64'(n_fail), CNT_W));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
         pass_q <= 1'b0;
         fail_q <= 1'b0;
         ovf_q  <= 1'b0;
         pcnt_q <= '0;
         fcnt_q <= '0;
      end else begin
         slot_q <= slot_d;
         pass_q <= pass_d;
         fail_q <= fail_d;
         ovf_q  <= ovf_d;
         pcnt_q <= pcnt_d;
         fcnt_q <= fcnt_d;
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int s = 0; s < N_SLOT; s++) busy_o = busy_o | slot_q[s].valid;
   end

   assign pass_o     = pass_q;
   assign fail_o     = fail_q;
   assign ovf_o      = ovf_q;
   assign pass_cnt_o = pcnt_q;
   assign fail_cnt_o = fcnt_q;

`ifdef SEQCHK_SVA_EN
   logic [ANT_LEN-1:0] sva_step;
   for (genvar k = 0; k < ANT_LEN; k++) begin : g_sva_step
      if (k == ANT_LEN - 1) begin : g_now
         assign sva_step[k] = en_i & ant_i[k];
      end else begin : g_past
         assign sva_step[k] = $past(en_i & ant_i[k], ANT_LEN - 1 - k, 1'b1, @(posedge clk));
      end
   end
   logic sva_ant;
   assign sva_ant = &sva_step;

   ref_a: assert property (@(posedge clk) disable iff (!rst_n)
      sva_ant |-> trig_i ##[MIN_DLY:MAX_DLY] resp_i);

   fail_imm_a: assert property (@(posedge clk) disable iff (!rst_n)
      (sva_ant && !trig_i) |=> fail_o);

   fail_to_a: assert property (@(posedge clk) disable iff (!rst_n)
      ((sva_ant && trig_i) ##MIN_DLY (!resp_i) [*(MAX_DLY - MIN_DLY + 1)])
      |=> (fail_o || ovf_o));

   pass_a: assert property (@(posedge clk) disable iff (!rst_n)
      ((sva_ant && trig_i) ##MIN_DLY (resp_i [->1] intersect 1'b1 [*1:(MAX_DLY - MIN_DLY + 1)]))
      |=> (pass_o || ovf_o));
`endif

endmodule

// File: rtl/seqchk_multi.sv
// Multi-channel checker for a ##1 b ##1 ... |-> d ##[MIN:MAX] e; one seqchk_chan per channel.
// Define SEQCHK_SVA_EN to include the reference assertions inside each channel.
module seqchk_multi
   import seqchk_pkg::*;
#(
   parameter int unsigned N_CH    = DEF_N_CH,
   parameter int unsigned ANT_LEN = DEF_ANT_LEN,
   parameter int unsigned MIN_DLY = DEF_MIN_DLY,
   parameter int unsigned MAX_DLY = DEF_MAX_DLY,
   parameter int unsigned N_SLOT  = DEF_N_SLOT,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en_i,
   input  logic [N_CH*ANT_LEN-1:0] ant_i,
   input  logic [N_CH-1:0]         trig_i,
   input  logic [N_CH-1:0]         resp_i,
   output logic [N_CH-1:0]         pass_o,
   output logic [N_CH-1:0]         fail_o,
   output logic [N_CH*CNT_W-1:0]   pass_cnt_o,
   output logic [N_CH*CNT_W-1:0]   fail_cnt_o,
   output logic [N_CH-1:0]         ovf_o,
   output logic [N_CH-1:0]         busy_o
);

   for (genvar c = 0; c < N_CH; c++) begin : g_chan
      seqchk_chan #(
         .ANT_LEN(ANT_LEN),
         .MIN_DLY(MIN_DLY),
         .MAX_DLY(MAX_DLY),
         .N_SLOT (N_SLOT),
         .CNT_W  (CNT_W)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .en_i      (en_i),
         .ant_i     (ant_i[c*ANT_LEN +: ANT_LEN]),
         .trig_i    (trig_i[c]),
         .resp_i    (resp_i[c]),
         .pass_o    (pass_o[c]),
         .fail_o    (fail_o[c]),
         .pass_cnt_o(pass_cnt_o[c*CNT_W +: CNT_W]),
         .fail_cnt_o(fail_cnt_o[c*CNT_W +: CNT_W]),
         .ovf_o     (ovf_o[c]),
         .busy_o    (busy_o[c])
      );
   end

endmodule

// File: tb/tb_seqchk_multi.sv
// Table-driven bench for seqchk_multi (defaults: 2 ch, 3-step antecedent, window 1..4, 4 slots).
// Expected outputs are queued as each cycle is driven and checked one edge later.
module tb_seqchk_multi;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_i = 1'b0;
   logic [5:0]  ant_i = '0;
   logic [1:0]  trig_i = '0;
   logic [1:0]  resp_i = '0;
   logic [1:0]  pass_o, fail_o, ovf_o, busy_o;
   logic [15:0] pass_cnt_o, fail_cnt_o;

   seqchk_multi dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en_i),
      .ant_i     (ant_i),
      .trig_i    (trig_i),
      .resp_i    (resp_i),
      .pass_o    (pass_o),
      .fail_o    (fail_o),
      .pass_cnt_o(pass_cnt_o),
      .fail_cnt_o(fail_cnt_o),
      .ovf_o     (ovf_o),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  pass, fail, busy, ovf;
      logic [15:0] pc, fc;
   } exp_t;

   typedef struct {
      logic       rst;
      logic       en;
      logic [5:0] ant;
      logic [1:0] trig, resp;
      exp_t       exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   nvec = 0;
   int   nerr = 0;

   function automatic exp_t mke(input logic [1:0] p, input logic [1:0] f, input logic [1:0] b,
                                input logic [1:0] o, input logic [7:0] pc0, input logic [7:0] fc0,
                                input logic [7:0] pc1, input logic [7:0] fc1);
      exp_t e;
      e.pass = p; e.fail = f; e.busy = b; e.ovf = o;
      e.pc = {pc1, pc0};
      e.fc = {fc1, fc0};
      return e;
   endfunction

   function automatic vec_t mk(input logic rst, input logic en, input logic [5:0] ant,
                               input logic [1:0] trig, input logic [1:0] resp,
                               input logic [1:0] p, input logic [1:0] f, input logic [1:0] b,
                               input logic [1:0] o, input logic [7:0] pc0, input logic [7:0] fc0,
                               input logic [7:0] pc1, input logic [7:0] fc1);
      vec_t v;
      v.rst = rst; v.en = en; v.ant = ant; v.trig = trig; v.resp = resp;
      v.exp = mke(p, f, b, o, pc0, fc0, pc1, fc1);
      return v;
   endfunction

   task automatic check_out(input string name);
      exp_t e;
      nvec++;
      if (sb.size() == 0) begin
         nerr++;
         $display("FAIL %s: no expected entry queued", name);
         return;
      end
      e = sb.pop_front();
      if ({pass_o, fail_o, busy_o, ovf_o, pass_cnt_o, fail_cnt_o} !==
          {e.pass, e.fail, e.busy, e.ovf, e.pc, e.fc}) begin
         nerr++;
         $display("FAIL %s: got pass=%b fail=%b busy=%b ovf=%b pcnt=%h fcnt=%h, want pass=%b fail=%b busy=%b ovf=%b pcnt=%h fcnt=%h",
                  name, pass_o, fail_o, busy_o, ovf_o, pass_cnt_o, fail_cnt_o,
                  e.pass, e.fail, e.busy, e.ovf, e.pc, e.fc);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en_i = 1'b0; ant_i = '0; trig_i = '0; resp_i = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Drive one cycle; optionally queue and check the outputs after the edge.
   task automatic step(input logic en, input logic [5:0] ant, input logic [1:0] trig,
                       input logic [1:0] resp, input bit chk, input exp_t e, input string name);
      en_i = en; ant_i = ant; trig_i = trig; resp_i = resp;
      if (chk) sb.push_back(e);
      @(posedge clk);
      #1;
      if (chk) check_out(name);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Pass at age 2.
      vecs.push_back(mk(1, 1, 6'b000001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000100, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b01, 1, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
      // Timeout fail at age MAX_DLY.
      vecs.push_back(mk(1, 1, 6'b000001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000100, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0));
      // Trigger low at match: immediate fail, no slot.
      vecs.push_back(mk(1, 1, 6'b000001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000100, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0));
      // Response at age 0 ignored, age 1 passes.
      vecs.push_back(mk(1, 1, 6'b000001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000100, 2'b01, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b01, 1, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
      // Overlapping antecedents 12..16: four slots fill, fifth dropped.
      vecs.push_back(mk(1, 1, 6'b000001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000011, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000111, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000111, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000111, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000110, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000100, 2'b01, 2'b00, 0, 1, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 1, 1, 1, 0, 2, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 1, 1, 1, 0, 3, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 1, 0, 1, 0, 4, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 0, 1, 0, 4, 0, 0));
      // One response satisfies two in-window slots.
      vecs.push_back(mk(1, 1, 6'b000001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000011, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000111, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000110, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b01, 1, 0, 0, 0, 2, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 0, 0, 2, 0, 0, 0));
      // ch0 immediate fail and ch1 pass together.
      vecs.push_back(mk(1, 1, 6'b001001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b010010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b100100, 2'b10, 2'b00, 0, 1, 2, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b10, 2, 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 6'b000000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0));
      // Enable low mid-antecedent breaks the chain.
      vecs.push_back(mk(1, 1, 6'b000001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 6'b000010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 6'b000100, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset state.
      do_reset();
      sb.push_back(mke(0, 0, 0, 0, 0, 0, 0, 0));
      check_out("reset_state");

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         step(vecs[i].en, vecs[i].ant, vecs[i].trig, vecs[i].resp, 1'b1, vecs[i].exp,
              $sformatf("vec%0d", i));
      end

      // Reset while an attempt is pending: outputs clear at once and no pulse follows.
      do_reset();
      step(1, 6'b000001, 2'b00, 2'b00, 1'b1, mke(0, 0, 0, 0, 0, 0, 0, 0), "arm_s0");
      step(1, 6'b000010, 2'b00, 2'b00, 1'b1, mke(0, 0, 0, 0, 0, 0, 0, 0), "arm_s1");
      step(1, 6'b000100, 2'b01, 2'b00, 1'b1, mke(0, 0, 1, 0, 0, 0, 0, 0), "arm_s2");
      en_i = 1'b0; ant_i = '0; trig_i = '0; resp_i = '0;
      #2 rst_n = 1'b0;
      #1;
      sb.push_back(mke(0, 0, 0, 0, 0, 0, 0, 0));
      check_out("async_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++)
         step(1, 6'b000000, 2'b00, 2'b00, 1'b1, mke(0, 0, 0, 0, 0, 0, 0, 0),
              $sformatf("post_reset%0d", i));

      // Continuous antecedent with trig low: one forced fail per cycle from index 2.
      for (int i = 0; i < 302; i++) begin
         if (i == 255)
            step(1, 6'b000111, 2'b00, 2'b00, 1'b1, mke(0, 1, 0, 0, 0, 254, 0, 0), "sat_254");
         else if (i == 256)
            step(1, 6'b000111, 2'b00, 2'b00, 1'b1, mke(0, 1, 0, 0, 0, 255, 0, 0), "sat_255");
         else if (i == 301)
            step(1, 6'b000111, 2'b00, 2'b00, 1'b1, mke(0, 1, 0, 0, 0, 255, 0, 0), "sat_hold");
         else
            step(1, 6'b000111, 2'b00, 2'b00, 1'b0, mke(0, 0, 0, 0, 0, 0, 0, 0), "");
      end
      step(1, 6'b000000, 2'b00, 2'b00, 1'b1, mke(0, 0, 0, 0, 0, 255, 0, 0), "sat_idle");

      if (sb.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/seqchk_multi.md
Name: seqchk_multi

Overview:
- Synthesizable, parametrised RTL checker for the implication `a ##1 b ##1 … |-> d ##[MIN:MAX] e`.
- Generalised over antecedent length, response window, channel count and concurrent attempts.
- Each channel independently detects overlapping antecedent matches and tracks pending attempts in slots. It reports pass/fail pulses, saturating counts and an overflow flag.
- Sits beside the DUT in the bench, or inside an FPGA debug build, as a hardware twin of the concurrent assertion.

Parameters:
- N_CH, 2, number of independent channels.
- ANT_LEN, 3, antecedent steps (>=1); step k must be high k cycles after step 0.
- MIN_DLY, 1, earliest cycle after d at which e satisfies the attempt (>=1).
- MAX_DLY, 4, latest such cycle (>=MIN_DLY).
- N_SLOT, 4, concurrent pending attempts per channel.
- CNT_W, 8, width of each saturating counter.

Ports:
- clk  in  1  sampling clock; all sampling on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en_i  in  1  enable; gates antecedent detection only.
- ant_i  in  N_CH*ANT_LEN  antecedent step bits; bit [c*ANT_LEN+k] is step k of channel c.
- trig_i  in  N_CH  consequent first term (d) per channel.
- resp_i  in  N_CH  response term (e) per channel.
- pass_o  out  N_CH  one-cycle pulse: at least one attempt passed.
- fail_o  out  N_CH  one-cycle pulse: at least one attempt failed.
- pass_cnt_o  out  N_CH*CNT_W  per-channel saturating pass count.
- fail_cnt_o  out  N_CH*CNT_W  per-channel saturating fail count.
- ovf_o  out  N_CH  sticky flag: an attempt was dropped because no slot was free.
- busy_o  out  N_CH  at least one slot valid.

Behaviour:
- Reset (async assert, sync-to-clk release): all slots invalid, progress registers 0, every output 0.
- Antecedent detection:
  - prog[k] is registered: steps 0..k matched, ending the previous cycle.
  - Match at cycle t = prog[ANT_LEN-2] & ant[ANT_LEN-1], sampled at t.
  - For ANT_LEN=1, match = ant[0].
  - Every start cycle is an independent attempt, so overlapping antecedents are all detected.
- en_i low: prog cleared and no new matches; pending slots keep aging and resolve normally.
- Match at t:
  - trig_i high at t: allocate the lowest free slot with age=0.
  - trig_i low at t: immediate fail; fail_o pulses at t+1 and no slot is used.
- Slot aging:
  - Age increments each cycle.
  - resp_i high at age in [MIN_DLY, MAX_DLY]: pass. The slot is freed and pass_o pulses the next cycle.
  - resp_i at age < MIN_DLY is ignored.
- Timeout: at age MAX_DLY with resp_i low, the attempt fails; fail_o pulses at t+MAX_DLY+1 and the slot is freed.
- One resp_i pulse satisfies every in-window slot simultaneously.
- Counters add the number of attempts resolved that cycle, saturating at 2^CNT_W-1.
  - pass_o and fail_o may both pulse in the same cycle.
- Slot reuse: a slot freed in cycle n is allocatable in cycle n+1, not n.
- No free slot at match:
  - The attempt is dropped and ovf_o sets, cleared only by reset.
  - A dropped attempt is counted in neither counter.
- Reset mid-operation discards all pending attempts with no pass/fail pulses.

Optional Feature:
- Macro: SEQCHK_SVA_EN.
- Defined: each channel contains a concurrent assertion of the same property, clocked @(posedge clk) and disabled iff !rst_n, plus a cross-check assertion. The cross-check:
  - requires fail_o[c] at t+1 whenever the reference assertion fails at t;
  - requires pass_o[c] consistency, unless ovf_o[c] is set.
- Not defined: the block is pure synthesizable RTL with no assertions; ports and timing are identical either way.

Decomposition:
- Package seqchk_pkg holds:
  - slot_t struct: valid, age [$clog2(MAX_DLY+1)].
  - Saturating-add function.
  - Default parameter constants.
- Sub-module seqchk_chan: one channel (progress chain, slot array, counters, ovf). seqchk_multi is a generate loop over N_CH instances plus port slicing.

Test Plan (defaults):
- ch0 steps at cycles 10/11/12, trig at 12, resp at 14 -> pass_o[0] at 15, pass_cnt 1, fail_cnt 0, busy low from 15.
- Same stimulus, resp never -> fail_o[0] at 17, fail_cnt 1.
- Antecedent completes at 12, trig low -> fail_o[0] at 13, no slot used (busy_o stays 0).
- Trig at 12 with resp at 12 (age 0) ignored, resp at 13 -> pass_o at 14. Also ch1 idle throughout -> all ch1 outputs 0.
- Antecedent + trig completing each cycle 12..16, no resp:
  - 4 slots fill and the 5th attempt (cycle 16) is dropped, setting ovf_o[0].
  - fail_o at 17..20 and fail_cnt 4.
- Arm at 12, rst_n low at 13:
  - all outputs 0 immediately, no pulse thereafter;
  - afterwards 300 forced fails -> fail_cnt saturates at 255.
